opcode_assembler: RTL and testbench
===================================

Name: opcode_assembler

Overview:
Parametrised successor to the fixed 3x32 opcode shift register. Accepts instruction words over a valid/ready stream, assembles NUM_WORDS words into one wide opcode, and presents the opcode to the decoder with a valid/ready handshake and backpressure. Sits between the command/SPI word interface and the GPU opcode decoder.

Parameters:
WORD_W, 32, width of one incoming word (>=1)
NUM_WORDS, 3, words per opcode (>=2)
TIMEOUT_CYCLES, 16, idle cycles before a partial frame is discarded (used only with OPCODE_ASM_TIMEOUT_EN; >=2)

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
clear  input  1  synchronous flush of partial/full frame
word_valid  input  1  word_in valid
word_in  input  WORD_W  incoming word
word_ready  output  1  assembler can accept word this cycle
opcode_valid  output  1  complete opcode held on opcode_out
opcode_ready  input  1  decoder consumes opcode
opcode_out  output  WORD_W*NUM_WORDS  assembled opcode
word_count  output  $clog2(NUM_WORDS+1)  words currently held (0..NUM_WORDS)
timeout_pulse  output  1  one-cycle pulse when a partial frame is dropped

Behaviour:
- Reset (n_rst=0, async): opcode_out=0, word_count=0, opcode_valid=0, timeout_pulse=0, state FILL.
- Word accepted on rising edge when word_valid && word_ready.
- Shift order: accepted word loads top slot [WORD_W*NUM_WORDS-1 -: WORD_W]; every slot moves down one word; bottom slot discarded. After N words A,B,C (N=3): opcode_out={C,B,A}.
- States: FILL (word_count<NUM_WORDS), FULL (word_count==NUM_WORDS).
- FILL: word_ready=1, opcode_valid=0; accept increments word_count; NUM_WORDS-th accept -> FULL next cycle (opcode_valid high one cycle after last word edge, zero extra latency).
- FULL: opcode_valid=1, opcode_out stable; word_ready=opcode_ready (pass-through).
- FULL, opcode_ready=1, no word: consume; word_count->0, state FILL; opcode_out retained (not zeroed).
- FULL, opcode_ready=1 and word accepted same cycle: consume + shift in; word_count->1, state FILL.
- FULL, opcode_ready=0: word_valid ignored, no shift, no count change.
- clear=1: word_count->0, opcode_out->0, state FILL, timeout counter->0; highest priority over accept and consume; any same-cycle word is dropped; opcode not delivered even if opcode_ready=1.
- word_valid while clear or full-and-stalled: word is not consumed (word_ready low for stalled; clear drops it).
- Counters never wrap: word_count saturates logically at NUM_WORDS via FULL state.

Optional Feature:
OPCODE_ASM_TIMEOUT_EN
- Defined: idle counter runs in FILL when 0<word_count<NUM_WORDS and no word accepted; resets on any accept, clear, or word_count==0. When it reaches TIMEOUT_CYCLES: word_count->0, opcode_out->0, timeout_pulse=1 for exactly one cycle. Accept in the expiry cycle wins (no timeout). FULL state never times out.
- Undefined: no idle counter; partial frames held indefinitely; timeout_pulse tied 0.

Test Plan:
- Reset: n_rst low mid-frame with word_count=2 -> all outputs 0 immediately, word_count=0, opcode_valid=0.
- Basic: send 0x1,0x2,0x3 back-to-back, opcode_ready=0 -> opcode_valid=1 on next cycle, opcode_out=0x00000003_00000002_00000001, word_ready=0.
- Backpressure: FULL with opcode_ready=0, drive word 0xDEAD for 5 cycles -> opcode_out unchanged, word_count=3; then opcode_ready=1 with 0xBEEF valid -> consumed, word_count=1, top word=0xBEEF.
- Random: 500 frames of random words, random opcode_ready gaps, NUM_WORDS=3 and a NUM_WORDS=4/WORD_W=16 build -> every delivered opcode equals {wN..w1} in order, no loss/duplication.
- Clear: two words loaded, clear=1 with word_valid=1 -> word_count=0, opcode_out=0, word dropped; clear in FULL with opcode_ready=1 -> no delivery.
- Timeout (macro on, TIMEOUT_CYCLES=16): one word then 16 idle cycles -> timeout_pulse one cycle, word_count=0; word on 16th cycle -> no pulse, word_count=2. Macro off -> no pulse after 100 idle cycles.

Source files
------------

// File: rtl/opcode_assembler.sv
// ---------------------------------------------------------------------------
// opcode_assembler
//
// Collects NUM_WORDS instruction words from a valid/ready word stream into a
// single wide opcode and offers it to the opcode decoder over a valid/ready
// handshake with backpressure. The newest word always enters the top slot and
// older words move down one slot, so after words A, B, C (NUM_WORDS=3) the
// opcode reads {C, B, A}.
//
// Parameters:
//   WORD_W          width of one incoming word (>=1)
//   NUM_WORDS       words per opcode (>=2)
//   TIMEOUT_CYCLES  idle cycles before a partial frame is dropped (>=2)
//
// Optional feature macro: OPCODE_ASM_TIMEOUT_EN
//   defined   - a partially filled frame left idle for TIMEOUT_CYCLES cycles
//               is discarded and timeout_pulse fires for one cycle
//   undefined - partial frames are held indefinitely, timeout_pulse is 0
//
// Ports:
//   clk            system clock, rising edge
//   n_rst          asynchronous active-low reset
//   clear          synchronous flush of any partial or full frame
//   word_valid     word_in is valid
//   word_in        incoming word
//   word_ready     a word can be accepted this cycle
//   opcode_valid   a complete opcode is held on opcode_out
//   opcode_ready   decoder consumes the opcode
//   opcode_out     assembled opcode
//   word_count     words currently held (0..NUM_WORDS)
//   timeout_pulse  one-cycle pulse when a partial frame is dropped
// ---------------------------------------------------------------------------
module opcode_assembler #(
    parameter int WORD_W         = 32,
    parameter int NUM_WORDS      = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          clear,
    input  logic                          word_valid,
    input  logic [WORD_W-1:0]             word_in,
    output logic                          word_ready,
    output logic                          opcode_valid,
    input  logic                          opcode_ready,
    output logic [WORD_W*NUM_WORDS-1:0]   opcode_out,
    output logic [$clog2(NUM_WORDS+1)-1:0] word_count,
    output logic                          timeout_pulse
);

    localparam int OP_W  = WORD_W * NUM_WORDS;
    localparam int CNT_W = $clog2(NUM_WORDS + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(NUM_WORDS);

    // Reject illegal configurations at elaboration time.
    if (WORD_W < 1 || NUM_WORDS < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("opcode_assembler: illegal parameter set");
    end

    typedef enum logic {
        S_FILL,
        S_FULL
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_d;
    logic [OP_W-1:0]   opcode_d;
    logic [OP_W-1:0]   shifted;
    logic              accept;

    // In FULL the word port is a pass-through of the decoder's ready: a word
    // can only enter in the same cycle the held opcode leaves.
    assign word_ready   = (state_q == S_FILL) || opcode_ready;
    assign opcode_valid = (state_q == S_FULL);

    // clear drops any same-cycle word even though word_ready may be high.
    assign accept  = word_valid && word_ready && !clear;
    assign shifted = {word_in, opcode_out[OP_W-1:WORD_W]};

`ifdef OPCODE_ASM_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES);

    logic [IDLE_W-1:0] idle_q;
    logic              timeout_hit;

    // idle_q counts completed idle cycles; the cycle that would make it
    // TIMEOUT_CYCLES is the expiry cycle. An accept in that cycle wins.
    assign timeout_hit = (state_q == S_FILL) && (word_count != '0) && !accept &&
                         !clear && (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            idle_q        <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= timeout_hit;
            if (clear || accept || timeout_hit || (word_count == '0) || (state_q == S_FULL))
                idle_q <= '0;
            else
                idle_q <= idle_q + IDLE_W'(1);
        end
    end
`else
    assign timeout_pulse = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first so no path can
        // leave it unassigned and infer a latch.
        state_d  = state_q;
        count_d  = word_count;
        opcode_d = opcode_out;

        if (clear) begin
            state_d  = S_FILL;
            count_d  = '0;
            opcode_d = '0;
        end else if (state_q == S_FILL) begin
            if (accept) begin
                opcode_d = shifted;
                count_d  = word_count + CNT_W'(1);
                if (word_count == FULL_COUNT - CNT_W'(1))
                    state_d = S_FULL;
            end
`ifdef OPCODE_ASM_TIMEOUT_EN
            else if (timeout_hit) begin
                count_d  = '0;
                opcode_d = '0;
            end
`endif
        end else if (opcode_ready) begin
            // Opcode consumed; a same-cycle word starts the next frame. The
            // old opcode stays visible on opcode_out until overwritten.
            state_d = S_FILL;
            if (accept) begin
                opcode_d = shifted;
                count_d  = CNT_W'(1);
            end else begin
                count_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= S_FILL;
            word_count <= '0;
            opcode_out <= '0;
        end else begin
            // NOTE: registered state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state_q    <= state_d;
            word_count <= count_d;
            opcode_out <= opcode_d;
        end
    end

endmodule

// File: tb/tb_opcode_assembler.sv
// ---------------------------------------------------------------------------
// tb_opcode_assembler
//
// Directed and randomized checks for opcode_assembler. Two instances are
// exercised: the default 32-bit x 3-word build and a 16-bit x 4-word build.
// The random scenarios use a queue-based model: words the model predicts are
// accepted are queued, a frame is the oldest NUM_WORDS words with the oldest
// in the lowest slot, and a delivery empties the queue.
// Timeout scenarios follow OPCODE_ASM_TIMEOUT_EN (TIMEOUT_CYCLES=16).
// ---------------------------------------------------------------------------
module tb_opcode_assembler;

    localparam int W    = 32;
    localparam int N    = 3;
    localparam int OPW  = W * N;
    localparam int CW   = $clog2(N + 1);
    localparam int W4   = 16;
    localparam int N4   = 4;
    localparam int OPW4 = W4 * N4;
    localparam int CW4  = $clog2(N4 + 1);

    logic            tb_clk;
    logic            n_rst;

    logic            clear;
    logic            word_valid;
    logic [W-1:0]    word_in;
    logic            word_ready;
    logic            opcode_valid;
    logic            opcode_ready;
    logic [OPW-1:0]  opcode_out;
    logic [CW-1:0]   word_count;
    logic            timeout_pulse;

    logic            clear4;
    logic            word_valid4;
    logic [W4-1:0]   word_in4;
    logic            word_ready4;
    logic            opcode_valid4;
    logic            opcode_ready4;
    logic [OPW4-1:0] opcode_out4;
    logic [CW4-1:0]  word_count4;
    logic            timeout_pulse4;

    int errors = 0;
    int checks = 0;

    opcode_assembler #(.WORD_W(W), .NUM_WORDS(N), .TIMEOUT_CYCLES(16)) dut (
        .clk          (tb_clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .word_valid   (word_valid),
        .word_in      (word_in),
        .word_ready   (word_ready),
        .opcode_valid (opcode_valid),
        .opcode_ready (opcode_ready),
        .opcode_out   (opcode_out),
        .word_count   (word_count),
        .timeout_pulse(timeout_pulse)
    );

    opcode_assembler #(.WORD_W(W4), .NUM_WORDS(N4), .TIMEOUT_CYCLES(16)) dut4 (
        .clk          (tb_clk),
        .n_rst        (n_rst),
        .clear        (clear4),
        .word_valid   (word_valid4),
        .word_in      (word_in4),
        .word_ready   (word_ready4),
        .opcode_valid (opcode_valid4),
        .opcode_ready (opcode_ready4),
        .opcode_out   (opcode_out4),
        .word_count   (word_count4),
        .timeout_pulse(timeout_pulse4)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    task automatic flush();
        word_valid   = 1'b0;
        opcode_ready = 1'b0;
        clear        = 1'b1;
        @(negedge tb_clk);
        clear        = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        clear = 1'b0; word_valid = 1'b0; word_in = '0; opcode_ready = 1'b0;
        clear4 = 1'b0; word_valid4 = 1'b0; word_in4 = '0; opcode_ready4 = 1'b0;
        repeat (2) @(negedge tb_clk);
        checks++;
        if (word_count !== '0 || opcode_valid !== 1'b0 || opcode_out !== '0 || timeout_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: count=%0d valid=%b out=%h pulse=%b, want 0/0/0/0",
                     word_count, opcode_valid, opcode_out, timeout_pulse);
        end
        n_rst = 1'b1;
        @(negedge tb_clk);
        word_valid = 1'b1;
        word_in = 32'hAAAA_0001; @(negedge tb_clk);
        word_in = 32'hAAAA_0002; @(negedge tb_clk);
        word_valid = 1'b0;
        checks++;
        if (word_count !== CW'(2)) begin
            errors++;
            $display("FAIL reset_preload: count=%0d want 2", word_count);
        end
        // Assert reset mid-cycle and look before any clock edge.
        #2 n_rst = 1'b0;
        #1;
        checks++;
        if (word_count !== '0 || opcode_valid !== 1'b0 || opcode_out !== '0 || timeout_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: count=%0d valid=%b out=%h pulse=%b, want 0/0/0/0",
                     word_count, opcode_valid, opcode_out, timeout_pulse);
        end
        @(negedge tb_clk);
        n_rst = 1'b1;
        @(negedge tb_clk);
    endtask

    task automatic test_basic();
        opcode_ready = 1'b0;
        word_valid   = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            word_in = W'(i);
            @(negedge tb_clk);
            if (i < 3) begin
                checks++;
                if (opcode_valid !== 1'b0 || word_count !== CW'(i)) begin
                    errors++;
                    $display("FAIL basic_partial_%0d: valid=%b count=%0d, want 0/%0d",
                             i, opcode_valid, word_count, i);
                end
            end
        end
        word_valid = 1'b0;
        checks++;
        if (opcode_valid !== 1'b1 || opcode_out !== 96'h00000003_00000002_00000001 ||
            word_ready !== 1'b0 || word_count !== CW'(3)) begin
            errors++;
            $display("FAIL basic_full: valid=%b out=%h ready=%b count=%0d, want 1/000000030000000200000001/0/3",
                     opcode_valid, opcode_out, word_ready, word_count);
        end
    endtask

    task automatic test_backpressure();
        opcode_ready = 1'b0;
        word_valid   = 1'b1;
        word_in      = 32'h0000_DEAD;
        for (int i = 0; i < 5; i++) begin
            @(negedge tb_clk);
            checks++;
            if (opcode_out !== 96'h00000003_00000002_00000001 || word_count !== CW'(3) ||
                opcode_valid !== 1'b1 || word_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_%0d: out=%h count=%0d valid=%b ready=%b, want held frame/3/1/0",
                         i, opcode_out, word_count, opcode_valid, word_ready);
            end
        end
        opcode_ready = 1'b1;
        word_in      = 32'h0000_BEEF;
        #1;
        checks++;
        if (word_ready !== 1'b1) begin
            errors++;
            $display("FAIL passthrough_ready: word_ready=%b want 1", word_ready);
        end
        @(negedge tb_clk);
        word_valid   = 1'b0;
        opcode_ready = 1'b0;
        checks++;
        if (word_count !== CW'(1) || opcode_valid !== 1'b0 ||
            opcode_out !== 96'h0000BEEF_00000003_00000002) begin
            errors++;
            $display("FAIL consume_and_load: count=%0d valid=%b out=%h, want 1/0/0000beef0000000300000002",
                     word_count, opcode_valid, opcode_out);
        end
    endtask

    task automatic test_clear();
        flush();
        word_valid = 1'b1;
        word_in = 32'h0000_000A; @(negedge tb_clk);
        word_in = 32'h0000_000B; @(negedge tb_clk);
        clear   = 1'b1;
        word_in = 32'h0000_000C;
        @(negedge tb_clk);
        clear      = 1'b0;
        word_valid = 1'b0;
        checks++;
        if (word_count !== '0 || opcode_out !== '0 || opcode_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_partial: count=%0d out=%h valid=%b, want 0/0/0",
                     word_count, opcode_out, opcode_valid);
        end
        word_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            word_in = W'(32'h11 + i);
            @(negedge tb_clk);
        end
        word_valid = 1'b0;
        checks++;
        if (opcode_valid !== 1'b1) begin
            errors++;
            $display("FAIL clear_prefill: valid=%b want 1", opcode_valid);
        end
        clear        = 1'b1;
        opcode_ready = 1'b1;
        @(negedge tb_clk);
        clear        = 1'b0;
        opcode_ready = 1'b0;
        checks++;
        if (word_count !== '0 || opcode_out !== '0 || opcode_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_full: count=%0d out=%h valid=%b, want 0/0/0",
                     word_count, opcode_out, opcode_valid);
        end
    endtask

    task automatic test_timeout();
        flush();
`ifdef OPCODE_ASM_TIMEOUT_EN
        word_valid = 1'b1;
        word_in    = 32'h55;
        @(negedge tb_clk);
        word_valid = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge tb_clk);
            if (i < 16) begin
                checks++;
                if (timeout_pulse !== 1'b0 || word_count !== CW'(1)) begin
                    errors++;
                    $display("FAIL timeout_early_%0d: pulse=%b count=%0d, want 0/1", i, timeout_pulse, word_count);
                end
            end
        end
        checks++;
        if (timeout_pulse !== 1'b1 || word_count !== '0 || opcode_out !== '0) begin
            errors++;
            $display("FAIL timeout_expire: pulse=%b count=%0d out=%h, want 1/0/0",
                     timeout_pulse, word_count, opcode_out);
        end
        @(negedge tb_clk);
        checks++;
        if (timeout_pulse !== 1'b0) begin
            errors++;
            $display("FAIL timeout_one_cycle: pulse=%b want 0", timeout_pulse);
        end
        word_valid = 1'b1;
        word_in    = 32'h66;
        @(negedge tb_clk);
        word_valid = 1'b0;
        repeat (15) @(negedge tb_clk);
        word_valid = 1'b1;
        word_in    = 32'h77;
        @(negedge tb_clk);
        word_valid = 1'b0;
        checks++;
        if (timeout_pulse !== 1'b0 || word_count !== CW'(2)) begin
            errors++;
            $display("FAIL timeout_accept_wins: pulse=%b count=%0d, want 0/2", timeout_pulse, word_count);
        end
        @(negedge tb_clk);
        checks++;
        if (timeout_pulse !== 1'b0 || word_count !== CW'(2)) begin
            errors++;
            $display("FAIL timeout_restart: pulse=%b count=%0d, want 0/2", timeout_pulse, word_count);
        end
`else
        word_valid = 1'b1;
        word_in    = 32'h55;
        @(negedge tb_clk);
        word_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge tb_clk);
            checks++;
            if (timeout_pulse !== 1'b0 || word_count !== CW'(1)) begin
                errors++;
                $display("FAIL no_timeout_%0d: pulse=%b count=%0d, want 0/1", i, timeout_pulse, word_count);
            end
        end
`endif
        flush();
    endtask

    task automatic test_random_3x32();
        logic [W-1:0]   q[$];
        logic [OPW-1:0] exp_op;
        logic           exp_ready;
        int frames   = 0;
        int fires    = 0;
        int idle_run = 0;
        int cyc      = 0;
        flush();
        while (frames < 500 && cyc < 20000) begin
            @(negedge tb_clk);
            cyc++;
            checks++;
            if (word_count !== CW'(q.size()) || opcode_valid !== (q.size() == N)) begin
                errors++;
                $display("FAIL rand3_state c%0d: count=%0d valid=%b, want %0d/%b",
                         cyc, word_count, opcode_valid, q.size(), q.size() == N);
            end
            if (q.size() == N) begin
                exp_op = '0;
                foreach (q[i]) exp_op[i*W +: W] = q[i];
                checks++;
                if (opcode_out !== exp_op) begin
                    errors++;
                    $display("FAIL rand3_frame %0d: out=%h want %h", frames, opcode_out, exp_op);
                end
            end
            word_valid   = ($urandom_range(0, 9) < 7) || (idle_run >= 4);
            word_in      = $urandom;
            opcode_ready = ($urandom_range(0, 2) != 0);
            #1;
            exp_ready = (q.size() < N) || opcode_ready;
            checks++;
            if (word_ready !== exp_ready) begin
                errors++;
                $display("FAIL rand3_ready c%0d: word_ready=%b want %b", cyc, word_ready, exp_ready);
            end
            if (q.size() == N && opcode_ready) begin
                frames++;
                q.delete();
                if (opcode_valid === 1'b1) fires++;
            end
            if (word_valid && exp_ready) begin
                q.push_back(word_in);
                idle_run = 0;
            end else begin
                idle_run++;
            end
        end
        checks++;
        if (frames != 500 || fires != frames) begin
            errors++;
            $display("FAIL rand3_totals: frames=%0d handshakes=%0d, want 500/500", frames, fires);
        end
        flush();
    endtask

    task automatic test_random_4x16();
        logic [W4-1:0]   q[$];
        logic [OPW4-1:0] exp_op;
        logic            exp_ready;
        int frames   = 0;
        int fires    = 0;
        int idle_run = 0;
        int cyc      = 0;
        word_valid4   = 1'b0;
        opcode_ready4 = 1'b0;
        clear4        = 1'b1;
        @(negedge tb_clk);
        clear4        = 1'b0;
        while (frames < 500 && cyc < 20000) begin
            @(negedge tb_clk);
            cyc++;
            checks++;
            if (word_count4 !== CW4'(q.size()) || opcode_valid4 !== (q.size() == N4)) begin
                errors++;
                $display("FAIL rand4_state c%0d: count=%0d valid=%b, want %0d/%b",
                         cyc, word_count4, opcode_valid4, q.size(), q.size() == N4);
            end
            if (q.size() == N4) begin
                exp_op = '0;
                foreach (q[i]) exp_op[i*W4 +: W4] = q[i];
                checks++;
                if (opcode_out4 !== exp_op) begin
                    errors++;
                    $display("FAIL rand4_frame %0d: out=%h want %h", frames, opcode_out4, exp_op);
                end
            end
            word_valid4   = ($urandom_range(0, 9) < 7) || (idle_run >= 4);
            word_in4      = W4'($urandom);
            opcode_ready4 = ($urandom_range(0, 3) != 0);
            #1;
            exp_ready = (q.size() < N4) || opcode_ready4;
            checks++;
            if (word_ready4 !== exp_ready) begin
                errors++;
                $display("FAIL rand4_ready c%0d: word_ready=%b want %b", cyc, word_ready4, exp_ready);
            end
            if (q.size() == N4 && opcode_ready4) begin
                frames++;
                q.delete();
                if (opcode_valid4 === 1'b1) fires++;
            end
            if (word_valid4 && exp_ready) begin
                q.push_back(word_in4);
                idle_run = 0;
            end else begin
                idle_run++;
            end
        end
        checks++;
        if (frames != 500 || fires != frames) begin
            errors++;
            $display("FAIL rand4_totals: frames=%0d handshakes=%0d, want 500/500", frames, fires);
        end
        word_valid4   = 1'b0;
        opcode_ready4 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_clear();
        test_timeout();
        test_random_3x32();
        test_random_4x16();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
